control_seq: RTL and testbench



---
 rtl/control_seq.sv | 145 ++++++++++++++
 tb/tb_control_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// Instruction fetch/decode/execute sequencer driving register-file load strobes.
// Stops in HALT on HLT, ack timeout or illegal opcode until reset.
module control_seq #(
   parameter int PC_W        = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [15:0]     mem_rdata,
   input  logic            mem_ack,
   output logic            mem_req,
   output logic [PC_W-1:0] mem_addr,
   output logic            rw,
   output logic            lsc,
   output logic            ldm,
   output logic            lacc,
   output logic [15:0]     load,
   output logic            busy,
   output logic            halted,
   output logic [1:0]      err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   logic [2:0]       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [15:0]      ir_q, ir_d;
   logic [15:0]      load_q, load_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       err_q, err_d;
   logic             rw_q, rw_d;
   logic             ldm_q, ldm_d;
   logic             lacc_q, lacc_d;
   logic             lsc_q, lsc_d;
   logic [3:0]       op;

   assign op = ir_q[15:12];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      load_d  = load_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rw_d    = 1'b0;
      ldm_d   = 1'b0;
      lacc_d  = 1'b0;
      lsc_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               cnt_d   = '0;
            end
         end
         S_FETCH: begin
            // an ack on the last allowed wait cycle still wins over timeout
            if (mem_ack) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + 1'b1;
               cnt_d   = '0;
               state_d = S_DECODE;
            end else if (cnt_q == CNT_LAST) begin
               if (err_q == 2'b00) err_d = 2'b01;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DECODE: begin
            load_d  = {4'b0000, ir_q[11:0]};
            state_d = S_EXEC;
            case (op)
               4'h1: begin ldm_d  = 1'b1; rw_d = 1'b1; end
               4'h2: begin lacc_d = 1'b1; rw_d = 1'b1; end
               4'h3: begin lsc_d  = 1'b1; rw_d = 1'b1; end
               default: ;
            endcase
         end
         S_EXEC: begin
            state_d = S_FETCH;
            cnt_d   = '0;
            case (op)
               4'h0, 4'h1, 4'h2, 4'h3: ;
               4'h4: pc_d = ir_q[PC_W-1:0];
               4'hF: state_d = S_HALT;
               default: begin
                  if (err_q == 2'b00) err_d = 2'b10;
                  state_d = S_HALT;
               end
            endcase
         end
         S_HALT: ;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         load_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 2'b00;
         rw_q    <= 1'b0;
         ldm_q   <= 1'b0;
         lacc_q  <= 1'b0;
         lsc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         load_q  <= load_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rw_q    <= rw_d;
         ldm_q   <= ldm_d;
         lacc_q  <= lacc_d;
         lsc_q   <= lsc_d;
      end
   end

   assign mem_req  = (state_q == S_FETCH);
   assign mem_addr = pc_q;
   assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE)
                  || (state_q == S_EXEC);
   assign halted   = (state_q == S_HALT);
   assign err      = err_q;
   assign load     = load_q;
   assign rw       = rw_q;
   assign ldm      = ldm_q;
   assign lacc     = lacc_q;
   assign lsc      = lsc_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq with a small behavioural program memory.
module tb_control_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        rw, lsc, ldm, lacc;
   logic [15:0] load;
   logic        busy, halted;
   logic [1:0]  err;

   logic [15:0] mem [256];
   logic        ack_en;
   int          n_tests = 0;
   int          n_fail  = 0;

   assign mem_rdata = mem[mem_addr];
   assign mem_ack   = mem_req & ack_en;

   control_seq #(.PC_W(8), .ACK_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .rw(rw), .lsc(lsc), .ldm(ldm), .lacc(lacc),
      .load(load), .busy(busy), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   // reset pulse off the clock edge, then a one-cycle start pulse
   task automatic reset_and_start();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst    = 1'b0;
      start  = 1'b0;
      ack_en = 1'b1;
      clear_mem();
      #3;
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_load", 32'(load), 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_strobes", 32'({rw, ldm, lacc, lsc}), 32'h0);
      tick();

      // LDM with immediate ack
      mem[0] = 16'h1006;
      mem[1] = 16'hF000;
      reset_and_start();
      chk("ldm_fetch_req", 32'(mem_req), 32'h1);
      chk("ldm_fetch_addr", 32'(mem_addr), 32'h0);
      chk("ldm_fetch_busy", 32'(busy), 32'h1);
      tick();
      chk("ldm_dec_strobes", 32'({rw, ldm, lacc, lsc}), 32'h0);
      chk("ldm_dec_addr", 32'(mem_addr), 32'h1);
      tick();
      chk("ldm_exec_strobes", 32'({rw, ldm, lacc, lsc}), 32'hC);
      chk("ldm_exec_load", 32'(load), 32'h0006);
      tick();
      chk("ldm_after_strobes", 32'({rw, ldm, lacc, lsc}), 32'h0);
      chk("ldm_after_addr", 32'(mem_addr), 32'h1);
      chk("ldm_after_load", 32'(load), 32'h0006);
      tick();
      tick();
      tick();
      chk("ldm_hlt_halted", 32'(halted), 32'h1);

      // LACC, LSC, HLT program
      clear_mem();
      mem[0] = 16'h2000;
      mem[1] = 16'h3000;
      mem[2] = 16'hF000;
      reset_and_start();
      tick();
      tick();
      chk("prog_lacc", 32'({rw, ldm, lacc, lsc}), 32'hA);
      tick();
      chk("prog_lacc_off", 32'({rw, ldm, lacc, lsc}), 32'h0);
      tick();
      tick();
      chk("prog_lsc", 32'({rw, ldm, lacc, lsc}), 32'h9);
      tick();
      chk("prog_lsc_off", 32'({rw, ldm, lacc, lsc}), 32'h0);
      tick();
      tick();
      chk("prog_hlt_exec", 32'({rw, ldm, lacc, lsc}), 32'h0);
      tick();
      chk("prog_halted", 32'(halted), 32'h1);
      chk("prog_busy", 32'(busy), 32'h0);
      chk("prog_err", 32'(err), 32'h0);

      // ack never arrives: 16 wait cycles then timeout
      clear_mem();
      ack_en = 1'b0;
      reset_and_start();
      for (int i = 0; i < 15; i++) tick();
      chk("to_c16_req", 32'(mem_req), 32'h1);
      chk("to_c16_err", 32'(err), 32'h0);
      tick();
      chk("to_err", 32'(err), 32'h1);
      chk("to_halted", 32'(halted), 32'h1);
      chk("to_req", 32'(mem_req), 32'h0);

      // ack on the 16th wait cycle is accepted
      mem[0] = 16'hF000;
      reset_and_start();
      for (int i = 0; i < 15; i++) tick();
      ack_en = 1'b1;
      tick();
      chk("ack16_err", 32'(err), 32'h0);
      chk("ack16_busy", 32'(busy), 32'h1);
      chk("ack16_addr", 32'(mem_addr), 32'h1);
      tick();
      tick();
      chk("ack16_halted", 32'(halted), 32'h1);
      chk("ack16_err_end", 32'(err), 32'h0);

      // illegal opcode
      clear_mem();
      mem[0] = 16'h7123;
      reset_and_start();
      tick();
      tick();
      chk("ill_strobes", 32'({rw, ldm, lacc, lsc}), 32'h0);
      tick();
      chk("ill_err", 32'(err), 32'h2);
      chk("ill_halted", 32'(halted), 32'h1);
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      chk("ill_start_ign", 32'(halted), 32'h1);
      chk("ill_start_req", 32'(mem_req), 32'h0);
      chk("ill_err_hold", 32'(err), 32'h2);

      // JMP chain and PC wrap
      clear_mem();
      mem[8'h00] = 16'h4010;
      mem[8'h10] = 16'h40FF;
      mem[8'hFF] = 16'h0000;
      reset_and_start();
      tick();
      tick();
      tick();
      chk("jmp_addr_10", 32'(mem_addr), 32'h10);
      tick();
      tick();
      tick();
      chk("jmp_addr_ff", 32'(mem_addr), 32'hFF);
      chk("jmp_req_ff", 32'(mem_req), 32'h1);
      tick();
      tick();
      chk("nop_strobes", 32'({rw, ldm, lacc, lsc}), 32'h0);
      tick();
      chk("wrap_addr", 32'(mem_addr), 32'h00);
      chk("wrap_req", 32'(mem_req), 32'h1);

      // async reset during EXEC of LDM
      clear_mem();
      mem[0] = 16'h1ABC;
      reset_and_start();
      tick();
      tick();
      chk("ar_ldm_on", 32'({rw, ldm, lacc, lsc}), 32'hC);
      chk("ar_load", 32'(load), 32'h0ABC);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_strobes", 32'({rw, ldm, lacc, lsc}), 32'h0);
      chk("ar_outs", 32'({mem_req, busy, halted, err}), 32'h0);
      chk("ar_load0", 32'(load), 32'h0);
      chk("ar_addr0", 32'(mem_addr), 32'h0);
      #1;
      rst = 1'b1;
      tick();
      tick();
      chk("ar_idle_busy", 32'(busy), 32'h0);
      chk("ar_idle_req", 32'(mem_req), 32'h0);
      chk("ar_idle_strobes", 32'({rw, ldm, lacc, lsc}), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
